// File: rtl/mso_cic_pkg.sv
// mso_cic_pkg: shared width helper, settle/run state encoding and rate clamp for the CIC decimator.
package mso_cic_pkg;

    typedef enum logic {ST_SETTLE = 1'b0, ST_RUN = 1'b1} cic_state_e;

    function automatic int cic_acc_width(input int x_width, input int m, input int rate_log2_max, input int d);
        return x_width + m * (rate_log2_max + d - 1);
    endfunction

    function automatic int cic_clamp_rate(input int rate, input int rate_max);
        return (rate > rate_max) ? rate_max : rate;
    endfunction

endpackage

// File: rtl/cic_channel_dp.sv
// cic_channel_dp: one channel's Hogenauer integrators, comb chain and unity-gain output scaler.
// Define CIC_DECIM_ROUND_EN for round-half-up scaling; otherwise the scaler truncates toward -inf.
module cic_channel_dp import mso_cic_pkg::*; #(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 12,
    parameter int M       = 3,
    parameter int D       = 1,
    parameter int ACC_W   = cic_acc_width(X_WIDTH, M, 6, D),
    parameter int SW      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic               acc_en_i,
    input  logic               launch_i,
    input  logic [M:0]         v_i,
    input  logic [SW-1:0]      s_i,
    input  logic [X_WIDTH-1:0] x_i,
    output logic [Y_WIDTH-1:0] y_o
);
    localparam int PW = ACC_W + Y_WIDTH - X_WIDTH + 1;

    logic [M-1:0][ACC_W-1:0]        acc_q, acc_d, c_q;
    logic [M-1:0][D-1:0][ACC_W-1:0] dly_q;
    logic [ACC_W-1:0]               l_q;
    logic [M:0][ACC_W-1:0]          ch;
    logic signed [PW-1:0]           p;
    logic [Y_WIDTH-1:0]             y_q, y_d;

    // ch[i] feeds comb stage i; ch[M] is the finished comb output
    always_comb begin
        acc_d = acc_q;
        acc_d[0] = acc_q[0] + {{(ACC_W-X_WIDTH){x_i[X_WIDTH-1]}}, x_i};
        for (int i = 1; i < M; i++) acc_d[i] = acc_q[i] + acc_q[i-1];
        ch = {c_q, l_q};
        p = {{(PW-ACC_W){ch[M][ACC_W-1]}}, ch[M]};
        p = p <<< (Y_WIDTH - X_WIDTH);
`ifdef CIC_DECIM_ROUND_EN
        if (s_i != '0) p = p + (PW'(1) <<< (s_i - 1'b1));
`endif
        y_d = Y_WIDTH'(p >>> s_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            acc_q <= '0;
            l_q   <= '0;
            c_q   <= '0;
            dly_q <= '0;
            y_q   <= '0;
        end else if (en_i) begin
            if (acc_en_i) acc_q <= acc_d;
            if (launch_i) l_q <= acc_d[M-1];
            for (int i = 0; i < M; i++) begin
                if (v_i[i]) begin
                    c_q[i] <= ch[i] - dly_q[i][D-1];
                    dly_q[i][0] <= ch[i];
                    for (int j = 1; j < D; j++) dly_q[i][j] <= dly_q[i][j-1];
                end
            end
            if (v_i[M]) y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/cic_decimator_mc.sv
// cic_decimator_mc: multi-channel runtime-rate CIC decimator; shared counter, settle FSM and valid pipe.
// CIC_DECIM_ROUND_EN selects round-half-up output scaling in every channel datapath.
module cic_decimator_mc import mso_cic_pkg::*; #(
    parameter int  CHANNELS      = 1,
    parameter int  X_WIDTH       = 12,
    parameter int  Y_WIDTH       = 12,
    parameter int  M             = 3,
    parameter int  D             = 1,
    parameter int  RATE_LOG2_MAX = 6,
    localparam int ACC_W         = cic_acc_width(X_WIDTH, M, RATE_LOG2_MAX, D),
    localparam int RW            = $clog2(RATE_LOG2_MAX + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [RW-1:0]                rate_log2,
    input  logic                         x_valid,
    input  logic [CHANNELS*X_WIDTH-1:0]  x,
    output logic                         y_valid,
    output logic [CHANNELS*Y_WIDTH-1:0]  y,
    output logic                         settling
);
    localparam int CW   = (RATE_LOG2_MAX > 0) ? RATE_LOG2_MAX : 1;
    localparam int SMAX = M * (RATE_LOG2_MAX + D - 1);
    localparam int SW   = (SMAX > 0) ? $clog2(SMAX + 1) : 1;
    localparam int FW   = $clog2(M * D + 1);
    localparam logic [FW-1:0] FLUSH_N = FW'(M * D);

    cic_state_e     st_q, st_d;
    logic [RW-1:0]  rate_q, rate_new;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]  flush_q, flush_d;
    logic [M:0]     v_q, v_d;
    logic           yv_q, yv_d, clr, acc_en, launch;
    logic [SW-1:0]  s;

    // v_q[0] marks the launch register, v_q[i+1] comb stage i; yv_q follows the scaler
    always_comb begin
        rate_new = RW'(cic_clamp_rate(int'(rate_log2), RATE_LOG2_MAX));
        clr      = enable && (rate_new != rate_q);
        acc_en   = enable && x_valid && !clr;
        launch   = acc_en && (cnt_q == CW'((1 << rate_q) - 1));
        s        = SW'(M * (int'(rate_q) + D - 1));
        cnt_d    = clr ? '0 : !acc_en ? cnt_q : launch ? '0 : cnt_q + 1'b1;
        v_d      = clr ? '0 : {v_q[M-1:0], launch};
        st_d     = clr ? ST_SETTLE : st_q;
        flush_d  = clr ? '0 : flush_q;
        yv_d     = !clr && v_q[M] && (st_q == ST_RUN);
        if (!clr && v_q[M] && (st_q == ST_SETTLE)) begin
            flush_d = flush_q + 1'b1;
            st_d    = (flush_d == FLUSH_N) ? ST_RUN : ST_SETTLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate_q  <= rate_new;
            cnt_q   <= '0;
            v_q     <= '0;
            yv_q    <= 1'b0;
            st_q    <= ST_SETTLE;
            flush_q <= '0;
        end else if (enable) begin
            rate_q  <= rate_new;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            yv_q    <= yv_d;
            st_q    <= st_d;
            flush_q <= flush_d;
        end
    end

    assign y_valid  = yv_q && enable;
    assign settling = (st_q == ST_SETTLE);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        cic_channel_dp #(
            .X_WIDTH (X_WIDTH),
            .Y_WIDTH (Y_WIDTH),
            .M       (M),
            .D       (D),
            .ACC_W   (ACC_W),
            .SW      (SW)
        ) u_dp (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (enable),
            .clr_i    (clr),
            .acc_en_i (acc_en),
            .launch_i (launch),
            .v_i      (v_q),
            .s_i      (s),
            .x_i      (x[c*X_WIDTH +: X_WIDTH]),
            .y_o      (y[c*Y_WIDTH +: Y_WIDTH])
        );
    end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// tb_cic_decimator_mc: randomized bench comparing cic_decimator_mc with an impulse-response model
// (boxcar convolution over the accepted-sample history, enabled-cycle latency, settle discard count).
module tb_cic_decimator_mc;
    localparam int CH = 4, XW = 12, YW = 14, M = 3, D = 1, RMAX = 6, RW = 3;

    typedef struct packed {
        int                rem;
        bit                sup;
        bit                last;
        logic [CH*YW-1:0]  ye;
    } ent_t;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, x_valid = 1'b0;
    logic [RW-1:0]    rate_log2 = '0;
    logic [CH*XW-1:0] x = '0;
    logic             y_valid, settling;
    logic [CH*YW-1:0] y;

    int n_cmp = 0, n_bad = 0;
    int pv = 100, pe = 100, xrand = 0;
    int act_rate = 0, n_acc = 0, n_launch = 0;
    bit m_settle = 1'b1;
    longint h[$];
    longint hist[CH][$];
    ent_t pend[$];

    always #5 clk = ~clk;

    cic_decimator_mc #(
        .CHANNELS(CH), .X_WIDTH(XW), .Y_WIDTH(YW), .M(M), .D(D), .RATE_LOG2_MAX(RMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rate_log2(rate_log2), .x_valid(x_valid),
        .x(x), .y_valid(y_valid), .y(y), .settling(settling)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // impulse response of M cascaded boxcars of length R*D
    task automatic set_rate(input int r);
        longint a[$], b[$];
        longint acc;
        int len;
        len = (1 << r) * D;
        act_rate = r;
        a = {64'sd1};
        repeat (M) begin
            b = {};
            for (int k = 0; k < a.size() + len - 1; k++) begin
                acc = 0;
                for (int j = 0; j < len; j++)
                    if (k - j >= 0 && k - j < a.size()) acc += a[k - j];
                b.push_back(acc);
            end
            a = b;
        end
        h = a;
    endtask

    task automatic clear_model(input int r);
        set_rate(r);
        for (int c = 0; c < CH; c++) hist[c].delete();
        n_acc = 0;
        n_launch = 0;
        m_settle = 1'b1;
        pend.delete();
    endtask

    // launch at sample n sees the integrator chain's M-1 sample pipeline lag
    function automatic logic [YW-1:0] ref_y(input int c, input int n);
        longint v;
        int s;
        v = 0;
        s = M * (act_rate + D - 1);
        for (int j = 0; j < h.size() && n - M + 1 - j >= 0; j++) v += h[j] * hist[c][n - M + 1 - j];
        v = v * (64'sd1 <<< (YW - XW));
`ifdef CIC_DECIM_ROUND_EN
        if (s > 0) v += 64'sd1 <<< (s - 1);
`endif
        v = v >>> s;
        return v[YW-1:0];
    endfunction

    task automatic model_edge();
        int r;
        r = (int'(rate_log2) > RMAX) ? RMAX : int'(rate_log2);
        if (!rst_n) clear_model(r);
        else if (enable) begin
            if (r != act_rate) clear_model(r);
            else begin
                for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].rem == 0) pend.delete(i);
                for (int i = 0; i < pend.size(); i++) begin
                    ent_t e = pend[i];
                    e.rem--;
                    if (e.rem == 0 && e.last) m_settle = 1'b0;
                    pend[i] = e;
                end
                if (x_valid) begin
                    for (int c = 0; c < CH; c++) hist[c].push_back(longint'($signed(x[c*XW +: XW])));
                    n_acc++;
                    if (n_acc % (1 << act_rate) == 0) begin
                        ent_t e;
                        n_launch++;
                        e.rem  = M + 1;
                        e.sup  = (n_launch <= M * D);
                        e.last = (n_launch == M * D);
                        e.ye   = '0;
                        for (int c = 0; c < CH; c++) e.ye[c*YW +: YW] = ref_y(c, n_acc - 1);
                        pend.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        logic [CH*YW-1:0] ye;
        bit ev, was_rst;
        if (xrand != 0) for (int c = 0; c < CH; c++) x[c*XW +: XW] = XW'($urandom);
        x_valid = ($urandom_range(99) < pv);
        enable  = ($urandom_range(99) < pe);
        was_rst = !rst_n;
        model_edge();
        @(posedge clk);
        #1;
        ev = 1'b0;
        ye = '0;
        foreach (pend[i]) if (pend[i].rem == 0 && !pend[i].sup) begin
            ev = 1'b1;
            ye = pend[i].ye;
        end
        ev = ev && enable;
        check("y_valid", 64'(y_valid), 64'(ev));
        check("settling", 64'(settling), 64'(m_settle));
        if (ev) check("y", 64'(y), 64'(ye));
        if (was_rst) check("y_after_reset", 64'(y), 64'd0);
    endtask

    initial begin
        rate_log2 = 3'd2;
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        for (int c = 0; c < CH; c++) x[c*XW +: XW] = XW'(100);
        repeat (80) cyc();
        xrand = 1;
        pv = 75;
        repeat (200) cyc();
        xrand = 0;
        pv = 100;
        rate_log2 = 3'd0;
        x = '0;
        repeat (20) cyc();
        for (int c = 0; c < CH; c++) x[c*XW +: XW] = XW'(2047 - c * 100);
        cyc();
        x = '0;
        repeat (20) cyc();
        rate_log2 = 3'd4;
        for (int c = 0; c < CH; c++) x[c*XW +: XW] = XW'($urandom_range(4095));
        repeat (300) cyc();
        rate_log2 = 3'd3;
        xrand = 1;
        pv = 80;
        repeat (40) cyc();
        pe = 0;
        repeat (10) cyc();
        pe = 100;
        repeat (60) cyc();
        pe = 80;
        repeat (300) cyc();
        pe = 100;
        rate_log2 = 3'd7;
        xrand = 0;
        pv = 100;
        x = {12'd1234, 12'hFFF, 12'd2047, 12'h800};
        repeat (340) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        rate_log2 = 3'd1;
        xrand = 1;
        repeat (200) cyc();
        pe = 90;
        pv = 70;
        repeat (20) begin
            rate_log2 = RW'($urandom_range(7));
            repeat (150) cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
